// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths and write-request type for the regfile writeback arbiter
// Purpose : default register bus widths (RegBus / RegAddrBus) and the {addr, data} write request.
// Ports   : none (package).
package regfile_wb_arbiter_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    typedef logic [REG_BUS_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

    typedef struct packed {
        reg_addr_bus_t addr;
        reg_bus_t      data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - bundled writeback, regfile-write and lookup signals
// Purpose : groups both writeback requesters, the regfile write port and the hazard lookup.
// Ports   : master = writeback/decode side, slave = arbiter side.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W
);
    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_addr;
    logic [DATA_W-1:0] wb0_data;
    logic              wb0_ready;
    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_addr;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_hit;
    logic              pend_busy;

    modport master (
        output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, chk_addr,
        input  wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, chk_hit, pend_busy
    );

    modport slave (
        input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, chk_addr,
        output wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, chk_hit, pend_busy
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_pend_fifo.sv
// rtl/regfile_wb_arbiter_wb_pend_fifo.sv - pending-write FIFO with two address compare ports
// Purpose : holds buffered requester-1 writes; reports whether any valid entry matches an address.
// Ports   : clk/rst; push_i + push_addr_i/push_data_i; pop_i; head_addr_o/head_data_o; count_o;
//           cmp0_addr_i -> cmp0_hit_o, cmp1_addr_i -> cmp1_hit_o (raw match, no x0 filtering).
module wb_pend_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DATA_W = REG_BUS_W,
    parameter  int ADDR_W = REG_ADDR_BUS_W,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic [ADDR_W-1:0] cmp0_addr_i,
    output logic              cmp0_hit_o,
    input  logic [ADDR_W-1:0] cmp1_addr_i,
    output logic              cmp1_hit_o
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  offset;
    logic              ent_valid;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // A slot is live when its distance from the read pointer is below count;
    // the pointer subtraction wraps because DEPTH is a power of two.
    always_comb begin
        cmp0_hit_o = 1'b0;
        cmp1_hit_o = 1'b0;
        offset     = '0;
        ent_valid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset    = PTR_W'(i) - rd_ptr_q;
            ent_valid = {1'b0, offset} < count_q;
            if (ent_valid && (addr_q[i] == cmp0_addr_i)) cmp0_hit_o = 1'b1;
            if (ent_valid && (addr_q[i] == cmp1_addr_i)) cmp1_hit_o = 1'b1;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between pipeline writeback and a long-latency unit
// Purpose : requester 1 is buffered and drained into idle write-port cycles, on a WAW conflict
//           with requester 0, or when the buffered head has waited STARVE_LIMIT cycles.
// Ports   : clk, rst (sync, active-high); bus (regfile_wb_arbiter_if.slave) carrying wb0_*, wb1_*,
//           rf_we/rf_waddr/rf_wdata, chk_addr/chk_hit and pend_busy.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = REG_BUS_W,
    parameter int ADDR_W       = REG_ADDR_BUS_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                wb0_hit;
    logic                chk_match;
    logic                push;
    logic                pop;
    logic                drain;
    logic                conflict;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    wb_pend_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (bus.wb1_addr),
        .push_data_i (bus.wb1_data),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count),
        .cmp0_addr_i (bus.wb0_addr),
        .cmp0_hit_o  (wb0_hit),
        .cmp1_addr_i (bus.chk_addr),
        .cmp1_hit_o  (chk_match)
    );

    always_comb begin
        // Draining an older buffered write to the same register first keeps WAW order.
        conflict = bus.wb0_valid && (bus.wb0_addr != '0) && wb0_hit;
        drain    = (count != '0) && (!bus.wb0_valid || conflict || (starve_cnt_q == LIMIT_C));
        pop      = drain && !rst;

        bus.wb1_ready = !rst && (count < DEPTH_C);
        // x0 handshakes are accepted but never stored.
        push          = bus.wb1_valid && bus.wb1_ready && (bus.wb1_addr != '0);
        bus.pend_busy = (count != '0);
        bus.chk_hit   = !rst && (bus.chk_addr != '0) && chk_match;

        if (drain) begin
            bus.wb0_ready = 1'b0;
            bus.rf_we     = !rst;
            bus.rf_waddr  = head_addr;
            bus.rf_wdata  = head_data;
        end else begin
            bus.wb0_ready = !rst;
            bus.rf_we     = !rst && bus.wb0_valid && (bus.wb0_addr != '0);
            bus.rf_waddr  = bus.wb0_addr;
            bus.rf_wdata  = bus.wb0_data;
        end

        if (pop || (count == '0)) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    regfile_wb_arbiter #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        bit in_rst;
        bit we;
        bit wb0_ready;
        bit wb1_ready;
        bit chk_hit;
        bit pend_busy;
    } status_t;

    typedef struct packed {
        logic    v;
        wb_req_t r;
    } stim_t;

    wb_req_t      wr_q[$];
    status_t      st_q[$];
    wb_req_t      pend[$];
    stim_t        q0[$];
    stim_t        q1[$];
    logic [4:0]   cq[$];
    int           starve = 0;
    int           checks = 0;
    int           failures = 0;
    bit           acc0, acc1;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: buffered writes as a plain queue, one call per clock cycle.
    task automatic model_step();
        status_t s;
        bit      conflict;
        bit      drain;
        int      cnt;
        wb_req_t w;
        s = '{default: 0};
        cnt = pend.size();
        if (rst) begin
            s.in_rst = 1;
            st_q.push_back(s);
            pend.delete();
            starve = 0;
            acc0 = 0;
            acc1 = 0;
            return;
        end
        conflict = 0;
        if (bif.wb0_valid && bif.wb0_addr != 0)
            foreach (pend[i]) if (pend[i].addr == bif.wb0_addr) conflict = 1;
        drain = (cnt > 0) && (!bif.wb0_valid || conflict || starve == LIMIT);
        s.wb0_ready = !drain;
        s.wb1_ready = cnt < DEPTH;
        s.pend_busy = cnt != 0;
        if (bif.chk_addr != 0)
            foreach (pend[i]) if (pend[i].addr == bif.chk_addr) s.chk_hit = 1;
        if (drain) begin
            wr_q.push_back(pend[0]);
            s.we = 1;
        end else if (bif.wb0_valid && bif.wb0_addr != 0) begin
            w.addr = bif.wb0_addr;
            w.data = bif.wb0_data;
            wr_q.push_back(w);
            s.we = 1;
        end
        acc0 = bif.wb0_valid && !drain;
        acc1 = bif.wb1_valid && s.wb1_ready;
        if (drain) void'(pend.pop_front());
        if (acc1 && bif.wb1_addr != 0) begin
            w.addr = bif.wb1_addr;
            w.data = bif.wb1_data;
            pend.push_back(w);
        end
        starve = (drain || cnt == 0) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
        st_q.push_back(s);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic add0(input bit v, input int a, input logic [31:0] d);
        stim_t s;
        s.v = v;
        s.r.addr = a[4:0];
        s.r.data = d;
        q0.push_back(s);
    endtask

    task automatic add1(input bit v, input int a, input logic [31:0] d);
        stim_t s;
        s.v = v;
        s.r.addr = a[4:0];
        s.r.data = d;
        q1.push_back(s);
    endtask

    task automatic drive_heads();
        if (q0.size() > 0) begin
            bif.wb0_valid = q0[0].v;
            bif.wb0_addr  = q0[0].r.addr;
            bif.wb0_data  = q0[0].r.data;
        end else begin
            bif.wb0_valid = 1'b0;
        end
        if (q1.size() > 0) begin
            bif.wb1_valid = q1[0].v;
            bif.wb1_addr  = q1[0].r.addr;
            bif.wb1_data  = q1[0].r.data;
        end else begin
            bif.wb1_valid = 1'b0;
        end
        if (cq.size() > 0) bif.chk_addr = cq.pop_front();
        else               bif.chk_addr = 5'($urandom_range(0, 15));
    endtask

    // Requesters hold a valid request until the model says it was accepted.
    task automatic run(input int max_cycles, input int idle_after);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cq.size() > 0) && n < max_cycles) begin
            drive_heads();
            cycle();
            if (q0.size() > 0 && (!q0[0].v || acc0)) void'(q0.pop_front());
            if (q1.size() > 0 && (!q1[0].v || acc1)) void'(q1.pop_front());
            n++;
        end
        compare("stim_drained", 32'(q0.size() + q1.size() + cq.size()), 32'd0);
        q0.delete();
        q1.delete();
        cq.delete();
        bif.wb0_valid = 1'b0;
        bif.wb1_valid = 1'b0;
        bif.chk_addr  = '0;
        repeat (idle_after) cycle();
    endtask

    // Monitor: consumes expectations each cycle, and a write record whenever the DUT writes.
    initial begin
        status_t s;
        wb_req_t e;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                compare("rf_we", 32'(bif.rf_we), 32'(s.we));
                compare("wb0_ready", 32'(bif.wb0_ready), 32'(s.wb0_ready));
                compare("wb1_ready", 32'(bif.wb1_ready), 32'(s.wb1_ready));
                if (!s.in_rst) begin
                    compare("chk_hit", 32'(bif.chk_hit), 32'(s.chk_hit));
                    compare("pend_busy", 32'(bif.pend_busy), 32'(s.pend_busy));
                end
            end
            if (bif.rf_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    compare("unexpected_write", 32'(bif.rf_waddr), 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    compare("rf_waddr", 32'(bif.rf_waddr), 32'(e.addr));
                    compare("rf_wdata", bif.rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        // Reset held three cycles with both requesters asserting.
        bif.wb0_valid = 1'b1; bif.wb0_addr = 5'd1; bif.wb0_data = 32'h1;
        bif.wb1_valid = 1'b1; bif.wb1_addr = 5'd2; bif.wb1_data = 32'h2;
        bif.chk_addr  = '0;
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        bif.wb0_valid = 1'b0;
        bif.wb1_valid = 1'b0;

        // Idle drain.
        add1(1, 5, 32'hDEADBEEF);
        run(20, 3);

        // Starvation: pipeline streams x1..x9 while x7 sits in the buffer.
        for (int a = 1; a <= 9; a++) add0(1, a, 32'h100 + 32'(a));
        add1(1, 7, 32'h77);
        run(40, 2);

        // Write-after-write on x3.
        add0(1, 1, 32'h1);
        add0(1, 3, 32'h22);
        add1(1, 3, 32'h11);
        run(20, 2);

        // Full buffer, held push, x0 push, x0 pipeline write.
        for (int k = 0; k < 10; k++) add0(1, 1 + (k % 2), 32'h200 + 32'(k));
        add0(1, 0, 32'h99);
        add1(1, 10, 32'hA0);
        add1(1, 11, 32'hB0);
        add1(1, 12, 32'hC0);
        add1(1, 0, 32'h5);
        run(60, 4);

        // Lookup on a buffered x12 before and after it drains.
        for (int k = 0; k < 6; k++) add0(1, 1 + k, 32'h300 + 32'(k));
        add1(1, 12, 32'hC12);
        cq.push_back(5'd12); cq.push_back(5'd12); cq.push_back(5'd0);
        cq.push_back(5'd13); cq.push_back(5'd12); cq.push_back(5'd12);
        cq.push_back(5'd12); cq.push_back(5'd12);
        run(40, 2);

        // Reset mid-operation with entries buffered: they must never be written.
        for (int k = 1; k <= 4; k++) add0(1, k, 32'h400 + 32'(k));
        add1(1, 20, 32'h2020);
        add1(1, 21, 32'h2121);
        run(20, 0);
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            add0($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom);
            add1($urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom);
        end
        run(8000, 0);

        repeat (DEPTH * (LIMIT + 1) + 3) cycle();
        @(negedge clk);
        #3;
        compare("writes_outstanding", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
